imem_byte_packer: RTL and testbench

IMEM_BYTE_PACKER -- requirements
Module: imem_byte_packer

---
 rtl/imem_byte_packer_if.sv | 27 ++
 rtl/imem_byte_packer.sv | 170 +++++++++++++++++
 tb/tb_imem_byte_packer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_byte_packer_if.sv
// Instruction-memory write bus between imem_byte_packer (master) and the memory (slave).
// The master holds mem_we, mem_addr and mem_wdata until the slave answers with mem_ready.
interface imem_byte_packer_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready
    );

endinterface

// File: rtl/imem_byte_packer.sv
// Packs a serial byte stream little-endian into 32-bit instruction words and writes them
// to instruction memory. Optional XOR checksum output is enabled by IMEM_PACK_CHECKSUM_EN.
module imem_byte_packer #(
    parameter int unsigned   DW        = 32,
    parameter int unsigned   AW        = 32,
    parameter logic [AW-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_en,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                grant,
    imem_byte_packer_if.master  mem,
    output logic                load_done,
    output logic                overrun,
    output logic [15:0]         word_count
`ifdef IMEM_PACK_CHECKSUM_EN
    ,
    output logic [31:0]         checksum
`endif
);

    localparam int unsigned LANES = DW / 8;
    localparam int unsigned LW    = $clog2(LANES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_bv_d;
    logic [LW-1:0]   r_lane;
    logic [DW-1:0]   r_asm;
    logic            r_grant;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_load_done;
    logic            r_overrun;
    logic [15:0]     r_word_count;

    logic            w_byte_edge;
    logic            w_last_lane;
    logic [DW-1:0]   w_asm_next;

    // Upstream holds byte_valid as a level; only its rising edge marks a new byte.
    assign w_byte_edge = byte_valid & ~r_bv_d;
    assign w_last_lane = (r_lane == LW'(LANES - 1));

    always_comb begin
        // NOTE: every always_comb output gets a full default first so no latch is inferred.
        w_asm_next                        = r_asm;
        w_asm_next[int'(r_lane) * 8 +: 8] = byte_in;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_bv_d       <= 1'b0;
            r_lane       <= '0;
            r_asm        <= '0;
            r_grant      <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= BASE_ADDR;
            r_mem_wdata  <= '0;
            r_load_done  <= 1'b0;
            r_overrun    <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_bv_d  <= byte_valid;
            r_grant <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (load_en) begin
                        r_state <= S_COLLECT;
                        r_lane  <= '0;
                        r_asm   <= '0;
                    end
                end

                S_COLLECT: begin
                    if (w_byte_edge) begin
                        r_grant <= 1'b1;
                        r_lane  <= r_lane + LW'(1);
                        if (w_last_lane) begin
                            r_mem_wdata <= w_asm_next;
                            r_asm       <= '0;
                            r_mem_we    <= 1'b1;
                            r_state     <= S_WRITE;
                        end else begin
                            r_asm <= w_asm_next;
                        end
                    end

                    // A byte arriving with the falling load_en counts toward the flush decision.
                    if (!load_en && !(w_byte_edge && w_last_lane)) begin
                        if (w_byte_edge || (r_lane != '0)) begin
                            r_mem_wdata <= w_byte_edge ? w_asm_next : r_asm;
                            r_asm       <= '0;
                            r_lane      <= '0;
                            r_mem_we    <= 1'b1;
                            r_state     <= S_FLUSH;
                        end else begin
                            r_load_done <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end

                S_WRITE, S_FLUSH: begin
                    if (w_byte_edge && (r_state == S_WRITE)) begin
                        r_overrun <= 1'b1;
                    end
                    if (mem.mem_ready) begin
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= r_mem_addr + AW'(4);
                        r_word_count <= r_word_count + 16'd1;
                        if ((r_state == S_WRITE) && load_en) begin
                            r_state <= S_COLLECT;
                        end else begin
                            r_load_done <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (load_en) begin
                        r_load_done <= 1'b0;
                        r_lane      <= '0;
                        r_asm       <= '0;
                        r_state     <= S_COLLECT;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant         = r_grant;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign load_done     = r_load_done;
    assign overrun       = r_overrun;
    assign word_count    = r_word_count;

`ifdef IMEM_PACK_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_checksum <= '0;
        end else if (r_mem_we && mem.mem_ready) begin
            r_checksum <= r_checksum ^ r_mem_wdata[31:0];
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_imem_byte_packer.sv
// Self-checking bench for imem_byte_packer: directed scenarios plus randomized loads
// compared against a byte-list reference model.
module tb_imem_byte_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        grant;
    logic        load_done;
    logic        overrun;
    logic [15:0] word_count;
`ifdef IMEM_PACK_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    imem_byte_packer_if #(.AW(32), .DW(32)) mem_if ();

    imem_byte_packer #(.DW(32), .AW(32), .BASE_ADDR(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .grant      (grant),
        .mem        (mem_if),
        .load_done  (load_done),
        .overrun    (overrun),
        .word_count (word_count)
`ifdef IMEM_PACK_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          grant_cnt = 0;
    bit          rand_ready = 1'b0;

    // Monitor on the falling edge: a write completes at the next rising edge.
    always @(negedge clk) begin
        if (rst && mem_if.mem_we && mem_if.mem_ready) begin
            wr_addr_q.push_back(mem_if.mem_addr);
            wr_data_q.push_back(mem_if.mem_wdata);
        end
        if (rst && grant) grant_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) mem_if.mem_ready = ($urandom_range(0, 1) == 1);
    endtask

    task automatic do_reset();
        rst = 1'b0; load_en = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        rand_ready = 1'b0; mem_if.mem_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        byte_in = b; byte_valid = 1'b1;
        repeat (hold) tick();
        byte_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_bus_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!mem_if.mem_we) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (load_done) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; load_en = 1'b0; byte_valid = 1'b0; mem_if.mem_ready = 1'b1;
        repeat (2) tick();
        n_checks++; if (grant !== 1'b0) $display("FAIL reset_grant: got %b want 0", grant); else n_pass++;
        n_checks++; if (mem_if.mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_if.mem_we); else n_pass++;
        n_checks++; if (mem_if.mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_if.mem_addr); else n_pass++;
        n_checks++; if (mem_if.mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h want 0", mem_if.mem_wdata); else n_pass++;
        n_checks++; if (load_done !== 1'b0) $display("FAIL reset_load_done: got %b want 0", load_done); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
        n_checks++; if (word_count !== 16'd0) $display("FAIL reset_word_count: got %0d want 0", word_count); else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        int gb, wb;
        bit ok;
        do_reset();
        load_en = 1'b1; repeat (2) tick();
        gb = grant_cnt; wb = wr_addr_q.size();
        send_byte(8'h13, 1, 2); send_byte(8'h00, 1, 2);
        send_byte(8'h00, 1, 2); send_byte(8'h00, 1, 2);
        n_checks++; if (wr_addr_q.size() - wb != 1) $display("FAIL single_writes: got %0d want 1", wr_addr_q.size() - wb); else n_pass++;
        if (wr_addr_q.size() - wb >= 1) begin
            n_checks++; if (wr_addr_q[wb] !== 32'h0) $display("FAIL single_addr: got %h want 0", wr_addr_q[wb]); else n_pass++;
            n_checks++; if (wr_data_q[wb] !== 32'h0000_0013) $display("FAIL single_data: got %h want 00000013", wr_data_q[wb]); else n_pass++;
        end
        n_checks++; if (grant_cnt - gb != 4) $display("FAIL single_grants: got %0d want 4", grant_cnt - gb); else n_pass++;
        n_checks++; if (word_count !== 16'd1) $display("FAIL single_word_count: got %0d want 1", word_count); else n_pass++;
        load_en = 1'b0;
        wait_done(20, ok);
        n_checks++; if (!ok) $display("FAIL single_load_done: got timeout want load_done=1"); else n_pass++;
    endtask

    task automatic test_level_hold();
        int gb, wb;
        do_reset();
        load_en = 1'b1; repeat (2) tick();
        gb = grant_cnt; wb = wr_addr_q.size();
        byte_in = 8'hAA; byte_valid = 1'b1;
        tick();
        n_checks++; if (grant !== 1'b1) $display("FAIL hold_grant_rise: got %b want 1", grant); else n_pass++;
        tick();
        n_checks++; if (grant !== 1'b0) $display("FAIL hold_grant_width: got %b want 0", grant); else n_pass++;
        repeat (7) tick();
        byte_valid = 1'b0; repeat (2) tick();
        n_checks++; if (grant_cnt - gb != 1) $display("FAIL hold_grants: got %0d want 1", grant_cnt - gb); else n_pass++;
        send_byte(8'h11, 1, 2); send_byte(8'h22, 1, 2); send_byte(8'h33, 1, 2);
        n_checks++;
        if (wr_data_q.size() - wb != 1 || wr_data_q[wr_data_q.size() - 1] !== 32'h3322_11AA)
            $display("FAIL hold_data: got %0d writes last %h want 1 write 332211aa", wr_data_q.size() - wb, wr_data_q[wr_data_q.size() - 1]);
        else n_pass++;
    endtask

    task automatic test_stall_overrun();
        int gb, wb, unstable;
        logic [31:0] cap_addr, cap_data;
        do_reset();
        load_en = 1'b1; repeat (2) tick();
        mem_if.mem_ready = 1'b0;
        gb = grant_cnt; wb = wr_addr_q.size();
        send_byte(8'hA1, 1, 2); send_byte(8'hA2, 1, 2);
        send_byte(8'hA3, 1, 2); send_byte(8'hA4, 1, 2);
        n_checks++; if (mem_if.mem_we !== 1'b1) $display("FAIL stall_we_pre: got %b want 1", mem_if.mem_we); else n_pass++;
        cap_addr = mem_if.mem_addr; cap_data = mem_if.mem_wdata;
        unstable = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin byte_in = 8'hEE; byte_valid = 1'b1; end
            if (c == 2) byte_valid = 1'b0;
            tick();
            if (mem_if.mem_we !== 1'b1 || mem_if.mem_addr !== cap_addr || mem_if.mem_wdata !== cap_data) unstable++;
        end
        n_checks++; if (unstable != 0) $display("FAIL stall_stable: got %0d unstable cycles want 0", unstable); else n_pass++;
        n_checks++; if (overrun !== 1'b1) $display("FAIL stall_overrun: got %b want 1", overrun); else n_pass++;
        n_checks++; if (grant_cnt - gb != 4) $display("FAIL stall_grants: got %0d want 4", grant_cnt - gb); else n_pass++;
        mem_if.mem_ready = 1'b1; repeat (2) tick();
        send_byte(8'hB1, 1, 2); send_byte(8'hB2, 1, 2);
        send_byte(8'hB3, 1, 2); send_byte(8'hB4, 1, 2);
        n_checks++;
        if (wr_data_q.size() - wb != 2) $display("FAIL stall_writes: got %0d want 2", wr_data_q.size() - wb);
        else if (wr_data_q[wb] !== 32'hA4A3_A2A1 || wr_data_q[wb + 1] !== 32'hB4B3_B2B1 || wr_addr_q[wb + 1] !== 32'h4)
            $display("FAIL stall_words: got %h %h @%h want a4a3a2a1 b4b3b2b1 @4", wr_data_q[wb], wr_data_q[wb + 1], wr_addr_q[wb + 1]);
        else n_pass++;
        n_checks++; if (overrun !== 1'b1) $display("FAIL stall_sticky: got %b want 1", overrun); else n_pass++;
        n_checks++; if (word_count !== 16'd2) $display("FAIL stall_word_count: got %0d want 2", word_count); else n_pass++;
    endtask

    task automatic test_flush();
        int wb;
        bit ok;
        do_reset();
        load_en = 1'b1; repeat (2) tick();
        wb = wr_addr_q.size();
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1, 2);
        load_en = 1'b0;
        wait_done(50, ok);
        n_checks++; if (!ok) $display("FAIL flush_done: got timeout want load_done=1"); else n_pass++;
        n_checks++;
        if (wr_addr_q.size() - wb != 2) $display("FAIL flush_writes: got %0d want 2", wr_addr_q.size() - wb);
        else if (wr_addr_q[wb] !== 32'h0 || wr_data_q[wb] !== 32'h0403_0201)
            $display("FAIL flush_word0: got %h@%h want 04030201@0", wr_data_q[wb], wr_addr_q[wb]);
        else if (wr_addr_q[wb + 1] !== 32'h4 || wr_data_q[wb + 1] !== 32'h0000_0605)
            $display("FAIL flush_word1: got %h@%h want 00000605@4", wr_data_q[wb + 1], wr_addr_q[wb + 1]);
        else n_pass++;
        n_checks++; if (word_count !== 16'd2) $display("FAIL flush_word_count: got %0d want 2", word_count); else n_pass++;
        n_checks++; if (mem_if.mem_we !== 1'b0) $display("FAIL flush_we_idle: got %b want 0", mem_if.mem_we); else n_pass++;
    endtask

    // Runs straight after test_flush: DONE with two words already written.
    task automatic test_done_reload();
        int gb, wb;
        gb = grant_cnt; wb = wr_addr_q.size();
        send_byte(8'h5A, 1, 3);
        n_checks++; if (grant_cnt != gb || wr_addr_q.size() != wb) $display("FAIL done_ignore: got %0d grants %0d writes want 0 0", grant_cnt - gb, wr_addr_q.size() - wb); else n_pass++;
        n_checks++; if (load_done !== 1'b1) $display("FAIL done_level: got %b want 1", load_done); else n_pass++;
        load_en = 1'b1; repeat (2) tick();
        n_checks++; if (load_done !== 1'b0) $display("FAIL reload_done_clr: got %b want 0", load_done); else n_pass++;
        send_byte(8'hC1, 1, 2); send_byte(8'hC2, 1, 2);
        send_byte(8'hC3, 1, 2); send_byte(8'hC4, 1, 2);
        n_checks++;
        if (wr_addr_q.size() - wb != 1 || wr_addr_q[wb] !== 32'h8 || wr_data_q[wb] !== 32'hC4C3_C2C1)
            $display("FAIL reload_word: got %0d writes want 1 write c4c3c2c1@8", wr_addr_q.size() - wb);
        else n_pass++;
        n_checks++; if (word_count !== 16'd3) $display("FAIL reload_word_count: got %0d want 3", word_count); else n_pass++;
        load_en = 1'b0; repeat (2) tick();
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        load_en = 1'b1; repeat (2) tick();
        for (int i = 0; i < 4; i++) send_byte(8'h70 + 8'(i), 1, 2);
        mem_if.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'h80 + 8'(i), 1, 2);
        n_checks++; if (mem_if.mem_we !== 1'b1 || mem_if.mem_addr !== 32'h4) $display("FAIL midrst_pre: got we=%b addr=%h want we=1 addr=4", mem_if.mem_we, mem_if.mem_addr); else n_pass++;
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++; if (mem_if.mem_we !== 1'b0) $display("FAIL midrst_we_async: got %b want 0", mem_if.mem_we); else n_pass++;
        load_en = 1'b0; mem_if.mem_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (mem_if.mem_addr !== 32'h0) $display("FAIL midrst_addr: got %h want 0", mem_if.mem_addr); else n_pass++;
        n_checks++; if (word_count !== 16'd0) $display("FAIL midrst_word_count: got %0d want 0", word_count); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [7:0]  bytes_q[$];
            logic [31:0] exp_words[$];
            int n, gb, wb, n_words, bad;
            bit ok;
            do_reset();
            rand_ready = 1'b1;
            load_en = 1'b1; repeat (2) tick();
            gb = grant_cnt; wb = wr_addr_q.size();
            n = $urandom_range(1, 13);
            for (int i = 0; i < n; i++) begin
                bytes_q.push_back(8'($urandom_range(0, 255)));
                wait_bus_idle(200, ok);
                if (!ok) begin n_checks++; $display("FAIL rand_bus_idle: got timeout want mem_we=0 (iter %0d)", it); end
                send_byte(bytes_q[i], $urandom_range(1, 4), $urandom_range(2, 3));
            end
            load_en = 1'b0;
            wait_done(300, ok);
            rand_ready = 1'b0; mem_if.mem_ready = 1'b1;
            n_checks++; if (!ok) $display("FAIL rand_done: got timeout want load_done=1 (iter %0d)", it); else n_pass++;
            // Reference: byte i lands in word i/4 at bit offset 8*(i%4), missing lanes stay zero.
            n_words = (n + 3) / 4;
            for (int w = 0; w < n_words; w++) exp_words.push_back(32'h0);
            for (int i = 0; i < n; i++) exp_words[i / 4] = exp_words[i / 4] | (32'(bytes_q[i]) << (8 * (i % 4)));
            n_checks++;
            if (wr_data_q.size() - wb != n_words) $display("FAIL rand_writes: got %0d want %0d (iter %0d)", wr_data_q.size() - wb, n_words, it);
            else begin
                bad = 0;
                for (int w = 0; w < n_words; w++)
                    if (wr_data_q[wb + w] !== exp_words[w] || wr_addr_q[wb + w] !== 32'(4 * w)) bad++;
                if (bad != 0) $display("FAIL rand_words: got %0d wrong words want 0 (iter %0d)", bad, it);
                else n_pass++;
            end
            n_checks++; if (grant_cnt - gb != n) $display("FAIL rand_grants: got %0d want %0d", grant_cnt - gb, n); else n_pass++;
            n_checks++; if (word_count !== 16'(n_words)) $display("FAIL rand_word_count: got %0d want %0d", word_count, n_words); else n_pass++;
            n_checks++; if (overrun !== 1'b0) $display("FAIL rand_overrun: got %b want 0", overrun); else n_pass++;
        end
    endtask

`ifdef IMEM_PACK_CHECKSUM_EN
    task automatic test_checksum();
        bit ok;
        do_reset();
        load_en = 1'b1; repeat (2) tick();
        send_byte(8'h78, 1, 2); send_byte(8'h56, 1, 2); send_byte(8'h34, 1, 2); send_byte(8'h12, 1, 2);
        send_byte(8'h00, 1, 2); send_byte(8'h00, 1, 2); send_byte(8'hFF, 1, 2); send_byte(8'hFF, 1, 2);
        load_en = 1'b0;
        wait_done(20, ok);
        n_checks++; if (checksum !== 32'hEDCB_5678) $display("FAIL checksum: got %h want edcb5678", checksum); else n_pass++;
    endtask
`endif

    initial begin
        mem_if.mem_ready = 1'b1;
        test_reset();
        test_single_word();
        test_level_hold();
        test_stall_overrun();
        test_flush();
        test_done_reload();
        test_reset_mid_write();
        test_random();
`ifdef IMEM_PACK_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before 2ms");
        $fatal(1);
    end

endmodule
